// File: rtl/uart_pkg.sv
// Shared types and helpers for the buffered UART transmitter.
// The frame-size helper is the single place the bit-count formula lives.
package uart_pkg;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_EVEN = 2'd1,
        PAR_ODD  = 2'd2
    } parity_e;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PAR,
        STOP
    } tx_state_e;

    // Bits on the wire per frame: start + data + optional parity + stop bits.
    function automatic int frame_bits(input int data_w, input int parity, input int stop_bits);
        return 1 + data_w + ((parity != 0) ? 1 : 0) + stop_bits;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers; occupancy, full and empty are
// all derived from the registered pointers, so they are glitch-free.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           rd_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr_reg;
    logic [AW:0]      rd_ptr_reg;
    logic             do_wr;
    logic             do_rd;

    assign do_wr = wr_en && !full;
    assign do_rd = rd_en && !empty;

    // Storage carries no reset so it maps onto plain RAM cells.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr_reg[AW-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_rd) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
        end
    end

    // Head word is visible combinationally so a pop can load it on the same edge.
    assign rd_data = mem[rd_ptr_reg[AW-1:0]];
    assign count   = wr_ptr_reg - rd_ptr_reg;
    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (wr_ptr_reg == rd_ptr_reg);

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: FIFO front end feeding a frame serialiser with
// configurable data width, parity and stop bits. TX lags the FSM by one clock.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 8,
    parameter int BAUD_DIV  = 2604,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wr_en,
    input  logic [DATA_W-1:0]         wr_data,
    input  logic                      clr_ovfl,
    output logic                      TX,
    output logic                      full,
    output logic                      empty,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      tx_busy,
    output logic                      tx_done,
    output logic                      ovfl
);

    localparam int BAUD_W  = $clog2(BAUD_DIV);
    localparam bit HAS_PAR = (PARITY != int'(PAR_NONE));
    localparam bit ODD_PAR = (PARITY == int'(PAR_ODD));

    if (DATA_W < 5 || DATA_W > 9) begin : g_bad_data_w
        $error("uart_tx_fifo: DATA_W must be 5..9");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("uart_tx_fifo: DEPTH must be a power of two >= 2");
    end
    if (BAUD_DIV < 4) begin : g_bad_baud
        $error("uart_tx_fifo: BAUD_DIV must be >= 4");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
        $error("uart_tx_fifo: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
        $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
    end

    tx_state_e         state_reg;
    tx_state_e         state_next;
    logic [BAUD_W-1:0] baud_cnt_reg;
    logic [3:0]        bit_cnt_reg;
    logic [DATA_W-1:0] shift_reg;
    logic              par_bit_reg;
    logic              tx_reg;
    logic              tx_done_reg;
    logic              ovfl_reg;

    logic              pop;
    logic              tx_bit;
    logic              done_next;
    logic              bit_tick;
    logic              last_data;
    logic              last_stop;
    logic [DATA_W-1:0] head;

    sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .rd_en   (pop),
        .rd_data (head),
        .count   (count),
        .full    (full),
        .empty   (empty)
    );

    assign bit_tick  = (baud_cnt_reg == BAUD_W'(BAUD_DIV - 1));
    assign last_data = (bit_cnt_reg == 4'(DATA_W - 1));
    assign last_stop = (bit_cnt_reg == 4'(STOP_BITS - 1));

    always_comb begin
        state_next = state_reg;
        pop        = 1'b0;
        tx_bit     = 1'b1;
        done_next  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (!empty) begin
                    pop        = 1'b1;
                    state_next = START;
                end
            end
            START: begin
                tx_bit = 1'b0;
                if (bit_tick) state_next = DATA;
            end
            DATA: begin
                tx_bit = shift_reg[0];
                if (bit_tick && last_data) state_next = HAS_PAR ? PAR : STOP;
            end
            PAR: begin
                tx_bit = par_bit_reg;
                if (bit_tick) state_next = STOP;
            end
            STOP: begin
                if (bit_tick && last_stop) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            tx_reg      <= 1'b1;
            tx_done_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            tx_reg      <= tx_bit;
            tx_done_reg <= done_next;
        end
    end

    // The bit counter restarts on every state change, so it counts data
    // bits in DATA and stop bits in STOP with one register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            baud_cnt_reg <= '0;
            bit_cnt_reg  <= '0;
            shift_reg    <= '0;
            par_bit_reg  <= 1'b0;
        end else begin
            if (state_reg == IDLE || bit_tick) begin
                baud_cnt_reg <= '0;
            end else begin
                baud_cnt_reg <= baud_cnt_reg + 1'b1;
            end

            if (state_next != state_reg) begin
                bit_cnt_reg <= '0;
            end else if (bit_tick) begin
                bit_cnt_reg <= bit_cnt_reg + 1'b1;
            end

            if (pop) begin
                shift_reg   <= head;
                par_bit_reg <= (^head) ^ ODD_PAR;
            end else if (state_reg == DATA && bit_tick) begin
                shift_reg <= shift_reg >> 1;
            end
        end
    end

    // A dropped push outranks a simultaneous clear so no overflow goes unseen.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovfl_reg <= 1'b0;
        end else if (wr_en && full) begin
            ovfl_reg <= 1'b1;
        end else if (clr_ovfl) begin
            ovfl_reg <= 1'b0;
        end
    end

    assign TX      = tx_reg;
    assign tx_busy = (state_reg != IDLE);
    assign tx_done = tx_done_reg;
    assign ovfl    = ovfl_reg;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: an 8N1 instance and an 8O2 instance,
// both at 16 clocks per bit, checked bit-by-bit against hand-built frames.
module tb_uart_tx_fifo;

    logic       clk;
    logic       rst;

    logic       wr_en_a, clr_a;
    logic [7:0] wr_data_a;
    logic       tx_a, full_a, empty_a, busy_a, done_a, ovfl_a;
    logic [3:0] count_a;

    logic       wr_en_b, clr_b;
    logic [7:0] wr_data_b;
    logic       tx_b, full_b, empty_b, busy_b, done_b, ovfl_b;
    logic [3:0] count_b;

    int n_checks = 0;
    int n_errors = 0;

    uart_tx_fifo #(
        .DATA_W(8), .DEPTH(8), .BAUD_DIV(16), .PARITY(0), .STOP_BITS(1)
    ) dut_a (
        .clk(clk), .rst(rst), .wr_en(wr_en_a), .wr_data(wr_data_a),
        .clr_ovfl(clr_a), .TX(tx_a), .full(full_a), .empty(empty_a),
        .count(count_a), .tx_busy(busy_a), .tx_done(done_a), .ovfl(ovfl_a)
    );

    uart_tx_fifo #(
        .DATA_W(8), .DEPTH(8), .BAUD_DIV(16), .PARITY(2), .STOP_BITS(2)
    ) dut_b (
        .clk(clk), .rst(rst), .wr_en(wr_en_b), .wr_data(wr_data_b),
        .clr_ovfl(clr_b), .TX(tx_b), .full(full_b), .empty(empty_b),
        .count(count_b), .tx_busy(busy_b), .tx_done(done_b), .ovfl(ovfl_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic line_of(input bit sel);
        return sel ? tx_b : tx_a;
    endfunction

    function automatic logic done_of(input bit sel);
        return sel ? done_b : done_a;
    endfunction

    // Entered one step after the edge where the start bit appears; samples
    // each bit mid-way and returns in the last clock of the frame.
    task automatic check_frame(input bit sel, input string tag, input logic [15:0] bits,
                               input int n, input int len_exp);
        int done_at = -1;
        int done_n  = 0;
        check({tag, "_start_edge"}, line_of(sel), 1'b0);
        for (int c = 0; c < 16 * n; c++) begin
            if (c % 16 == 8) begin
                check($sformatf("%s_bit%0d", tag, c / 16), line_of(sel), bits[c / 16]);
            end
            if (done_of(sel)) begin
                if (done_at < 0) done_at = c;
                done_n++;
            end
            if (c != 16 * n - 1) tick();
        end
        check({tag, "_frame_len"}, done_at + 1, len_exp);
        check({tag, "_done_pulses"}, done_n, 1);
        $display("frame %s: %0d bits sampled, tx_done at clock %0d", tag, n, done_at + 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        wr_en_a = 1'b0; clr_a = 1'b0; wr_data_a = '0;
        wr_en_b = 1'b0; clr_b = 1'b0; wr_data_b = '0;
        tick(); tick();

        check("rst_tx",    tx_a,    1'b1);
        check("rst_full",  full_a,  1'b0);
        check("rst_empty", empty_a, 1'b1);
        check("rst_count", count_a, 4'd0);
        check("rst_busy",  busy_a,  1'b0);
        check("rst_done",  done_a,  1'b0);
        check("rst_ovfl",  ovfl_a,  1'b0);
        check("rst_tx_b",  tx_b,    1'b1);
        check("rst_cnt_b", count_b, 4'd0);
        check("rst_full_b", full_b, 1'b0);
        check("rst_empty_b", empty_b, 1'b1);
        rst = 1'b0;
        tick();

        // Single 8N1 frame of 0x67.
        wr_en_a = 1'b1; wr_data_a = 8'h67;
        tick();
        wr_en_a = 1'b0;
        check("push_empty", empty_a, 1'b0);
        check("push_count", count_a, 4'd1);
        check("push_busy",  busy_a,  1'b0);
        check("push_tx",    tx_a,    1'b1);
        tick();
        check("pop_busy",  busy_a,  1'b1);
        check("pop_count", count_a, 4'd0);
        check("pop_tx",    tx_a,    1'b1);
        tick();
        check_frame(1'b0, "single", {6'd0, 1'b1, 8'h67, 1'b0}, 10, 160);
        tick();
        check("single_idle_tx",   tx_a,   1'b1);
        check("single_idle_busy", busy_a, 1'b0);

        // Burst of ten pushes; the tenth is dropped with clr_ovfl asserted.
        fork
            begin
                for (int i = 1; i <= 10; i++) begin
                    wr_en_a = 1'b1; wr_data_a = 8'(i); clr_a = (i == 10);
                    tick();
                end
                wr_en_a = 1'b0; clr_a = 1'b0;
                check("burst_ovfl_set", ovfl_a,  1'b1);
                check("burst_count",    count_a, 4'd8);
                check("burst_full",     full_a,  1'b1);
            end
            begin
                tick(); tick(); tick();
                for (int f = 1; f <= 9; f++) begin
                    check_frame(1'b0, $sformatf("burst%0d", f), {6'd0, 1'b1, 8'(f), 1'b0}, 10, 160);
                    tick();
                    check($sformatf("burst%0d_gap", f), tx_a, 1'b1);
                    if (f < 9) tick();
                end
                check("burst_end_busy",  busy_a,  1'b0);
                check("burst_end_empty", empty_a, 1'b1);
            end
        join
        clr_a = 1'b1;
        tick();
        clr_a = 1'b0;
        check("ovfl_cleared", ovfl_a, 1'b0);

        // Push on the same edge as the pop, with one word queued.
        wr_en_a = 1'b1; wr_data_a = 8'hA5;
        tick();
        wr_data_a = 8'h3C;
        tick();
        wr_en_a = 1'b0;
        check("pushpop_count", count_a, 4'd1);
        check("pushpop_busy",  busy_a,  1'b1);
        tick();
        check_frame(1'b0, "pushpop1", {6'd0, 1'b1, 8'hA5, 1'b0}, 10, 160);
        tick();
        check("pushpop_gap", tx_a, 1'b1);
        tick();
        check_frame(1'b0, "pushpop2", {6'd0, 1'b1, 8'h3C, 1'b0}, 10, 160);
        tick();
        check("pushpop_idle", busy_a, 1'b0);

        // Odd parity, two stop bits: 0x73 has five ones, so parity is 0.
        wr_en_b = 1'b1; wr_data_b = 8'h73;
        tick();
        wr_en_b = 1'b0;
        tick(); tick();
        check_frame(1'b1, "par_odd", {4'd0, 2'b11, 1'b0, 8'h73, 1'b0}, 12, 192);
        tick();
        check("par_idle_tx",   tx_b,   1'b1);
        check("par_idle_busy", busy_b, 1'b0);
        check("par_ovfl_b",    ovfl_b, 1'b0);

        // Reset in the middle of data bit 3 of 0x55 (that bit is 0).
        wr_en_a = 1'b1; wr_data_a = 8'h55;
        tick();
        wr_en_a = 1'b0;
        tick(); tick();
        repeat (70) tick();
        check("rst_mid_pre_tx", tx_a, 1'b0);
        rst = 1'b1;
        #1;
        check("rst_mid_tx",    tx_a,    1'b1);
        check("rst_mid_count", count_a, 4'd0);
        check("rst_mid_busy",  busy_a,  1'b0);
        check("rst_mid_empty", empty_a, 1'b1);
        tick(); tick();
        rst = 1'b0;
        tick();
        wr_en_a = 1'b1; wr_data_a = 8'hC3;
        tick();
        wr_en_a = 1'b0;
        tick(); tick();
        check_frame(1'b0, "after_rst", {6'd0, 1'b1, 8'hC3, 1'b0}, 10, 160);
        tick();
        check("after_rst_idle", busy_a, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
